load_unit: RTL and testbench

- Load-side counterpart of the store formatting path in the MEM stage.
- Accepts one load request from the pipeline and issues a word-aligned read on the data-memory port. It waits for the memory response, then extracts, aligns and sign- or zero-extends the addressed byte, halfword or word.
- Holds the result for writeback until the pipeline acknowledges it.
- Sits between the EX/MEM register and the data cache; its busy indication stalls the pipeline.

---
 rtl/rv32i_types.sv | 29 ++
 rtl/load_formatter.sv | 34 +++
 rtl/load_unit.sv | 166 ++++++++++++++++
 tb/tb_load_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the MEM-stage load path.
package rv32i_types;

  // funct3 encodings of the RV32I load instructions
  typedef enum logic [2:0] {
    LF3_LB  = 3'b000,
    LF3_LH  = 3'b001,
    LF3_LW  = 3'b010,
    LF3_LBU = 3'b100,
    LF3_LHU = 3'b101
  } load_funct3_t;

  // Load unit control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } load_unit_state_t;

  // True when the access is not naturally aligned for its size
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if ((funct3 == LF3_LH) || (funct3 == LF3_LHU)) mis = offset[0];
    else if (funct3 == LF3_LW)                     mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the addressed byte/halfword/word
// from a 32-bit memory word and sign- or zero-extends it.
// Shared between the load unit and the forwarding path.
module load_formatter
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_shift = rdata >> {offset, 3'b000};
  assign byte_v     = byte_shift[7:0];
  // offset[0] is deliberately ignored for halfwords
  assign half_v     = offset[1] ? rdata[31:16] : rdata[15:0];

  // Extend according to the load type; undefined encodings pass the word through
  always_comb begin
    result = rdata;
    case (funct3)
      LF3_LB:  result = {{24{byte_v[7]}}, byte_v};
      LF3_LBU: result = {24'h000000, byte_v};
      LF3_LH:  result = {{16{half_v[15]}}, half_v};
      LF3_LHU: result = {16'h0000, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: issues a word-aligned read, waits for the memory
// response (with an optional watchdog), formats the data and holds the
// result until writeback acknowledges it.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned lh/lhu/lw skip the memory
// access and complete immediately with err_misaligned set.
module load_unit
  import rv32i_types::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic        dmem_read,
  output logic [31:0] dmem_address,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  input  logic        rsp_ack,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_misaligned
);

  // Watchdog fires on the cycle the 8-bit counter reaches MAX_WAIT-1
  localparam bit         WDOG_EN  = (MAX_WAIT != 0);
  localparam logic [7:0] LAST_CNT = (MAX_WAIT == 0) ? 8'd0 : 8'(MAX_WAIT - 1);

  load_unit_state_t state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic        dmem_read_q, dmem_read_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_mis_q, err_mis_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] fmt_result;

  load_formatter u_fmt (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (fmt_result)
  );

  // Next-state and output-register logic for the request/wait/hold sequence
  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    addr_d        = addr_q;
    dmem_read_d   = dmem_read_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    err_timeout_d = err_timeout_q;
    err_mis_d     = err_mis_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d      = req_addr[1:0];
          funct3_d   = req_funct3;
          rd_d       = req_rd;
          addr_d     = {req_addr[31:2], 2'b00};
          wait_cnt_d = 8'd0;
`ifdef LOAD_MISALIGN_TRAP_EN
          if (is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0;
            err_mis_d   = 1'b1;
          end else
`endif
          begin
            dmem_read_d = 1'b1;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // A response in the timeout cycle still wins
        if (dmem_resp) begin
          rsp_data_d  = fmt_result;
          dmem_read_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else if (WDOG_EN && (wait_cnt_q == LAST_CNT)) begin
          rsp_data_d    = 32'h0;
          dmem_read_d   = 1'b0;
          err_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        // No request is taken here even if req_valid rides along with rsp_ack
        if (rsp_ack) begin
          rsp_valid_d   = 1'b0;
          err_timeout_d = 1'b0;
          err_mis_d     = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        dmem_read_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops the read strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= 2'b00;
      funct3_q      <= 3'b000;
      rd_q          <= 5'd0;
      addr_q        <= 32'h0;
      dmem_read_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      err_timeout_q <= 1'b0;
      err_mis_q     <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      dmem_read_q   <= dmem_read_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      err_timeout_q <= err_timeout_d;
      err_mis_q     <= err_mis_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dmem_read    = dmem_read_q;
  assign dmem_address = addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_rd       = rd_q;
  assign err_timeout  = err_timeout_q;
`ifdef LOAD_MISALIGN_TRAP_EN
  assign err_misaligned = err_mis_q;
`else
  assign err_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against a transaction-level
// model (response delay vs. watchdog limit, arithmetic data extraction).
module tb_load_unit;

  localparam int MW = 6;
`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [4:0]  req_rd = 5'd0;
  logic        dmem_read;
  logic [31:0] dmem_address;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_ack = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic        err_misaligned;

  int total = 0;
  int bad   = 0;

  load_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .dmem_read(dmem_read), .dmem_address(dmem_address),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_ack(rsp_ack), .busy(busy),
    .err_timeout(err_timeout), .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference extraction using plain shifts, masks and arithmetic
  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    if (f3 == 3'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // One load transaction; caller is 1 time unit after a posedge with the DUT idle.
  // delay = WAIT cycle (1-based) on which dmem_resp is pulsed.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int delay, input int hold,
                         input bit ack_with_req, input bit late_resp);
    logic [4:0]  rd;
    logic [31:0] exp_data;
    bit          exp_to, exp_mis, finished;
    int          waited;
    rd = 5'($urandom);
    exp_data = 32'h0; exp_to = 0; exp_mis = 0; finished = 0; waited = 0;
    chk({name, ":idle_ready"}, req_ready, 1);
    chk({name, ":idle_busy"}, busy, 0);
    req_valid = 1; req_addr = addr; req_funct3 = f3; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_funct3 = 3'($urandom); req_rd = 5'($urandom);
    if (TRAP && ref_misaligned(addr, f3)) begin
      exp_mis = 1; finished = 1;
    end else begin
      for (int k = 1; k <= 64; k++) begin
        chk({name, ":rd_strobe"}, dmem_read, 1);
        chk({name, ":address"}, dmem_address, addr & 32'hFFFF_FFFC);
        chk({name, ":busy_wait"}, busy, 1);
        chk({name, ":no_early_rsp"}, rsp_valid, 0);
        waited = k;
        if (k == delay) begin
          dmem_resp = 1; dmem_rdata = rdata;
          @(posedge clk); #1;
          dmem_resp = 0; dmem_rdata = $urandom;
          exp_data = ref_fmt(rdata, addr[1:0], f3);
          finished = 1;
          break;
        end
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        if (MW != 0 && k == MW) begin
          exp_to = 1; finished = 1;
          break;
        end
      end
    end
    chk({name, ":wait_bound"}, finished, 1);
    // Result held through DONE until acknowledged
    for (int h = 0; h <= hold; h++) begin
      chk({name, ":rsp_valid"}, rsp_valid, 1);
      chk({name, ":rsp_data"}, rsp_data, exp_data);
      chk({name, ":rsp_rd"}, rsp_rd, rd);
      chk({name, ":err_timeout"}, err_timeout, exp_to);
      chk({name, ":err_misaligned"}, err_misaligned, exp_mis);
      chk({name, ":done_no_read"}, dmem_read, 0);
      chk({name, ":done_ready"}, req_ready, 0);
      chk({name, ":done_busy"}, busy, 1);
      if (h == hold) break;
      req_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rsp_ack = 1; req_valid = ack_with_req;
    @(posedge clk); #1;
    rsp_ack = 0;
    chk({name, ":ack_clears"}, rsp_valid, 0);
    chk({name, ":no_accept_on_ack"}, dmem_read, 0);
    chk({name, ":idle_after_ack"}, req_ready, 1);
    chk({name, ":err_to_clear"}, err_timeout, 0);
    chk({name, ":err_mis_clear"}, err_misaligned, 0);
    req_valid = 0;
    if (late_resp) begin
      dmem_resp = 1; dmem_rdata = $urandom;
      @(posedge clk); #1;
      dmem_resp = 0;
      chk({name, ":late_resp_ignored"}, rsp_valid, 0);
      chk({name, ":late_resp_busy"}, busy, 0);
    end
    $display("txn %s addr=%08h f3=%0d delay=%0d waited=%0d exp=%08h to=%0d mis=%0d",
             name, addr, f3, delay, waited, exp_data, exp_to, exp_mis);
  endtask

  initial begin
    #3;
    chk("rst_read", dmem_read, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_rd", rsp_rd, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_err_mis", err_misaligned, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Directed cases
    do_load("lb_1003", 32'h0000_1003, 3'd0, 32'h80FF_1234, 1, 0, 0, 0);
    do_load("lhu_2002", 32'h0000_2002, 3'd5, 32'hBEEF_0011, 5, 3, 0, 0);
    do_load("lw_timeout", 32'h0000_3000, 3'd2, 32'h1234_5678, 100, 1, 0, 1);
    do_load("resp_at_limit", 32'h0000_3004, 3'd2, 32'hCAFE_F00D, MW, 0, 0, 0);
    do_load("b2b_ack_req", 32'h0000_3008, 3'd4, 32'h0000_00A5, 2, 1, 1, 0);
    do_load("lh_4001", 32'h0000_4001, 3'd1, 32'h1234_8765, 2, 1, 0, 0);
    do_load("f3_undef", 32'h0000_4003, 3'd7, 32'h89AB_CDEF, 3, 0, 0, 0);

    // Reset in the middle of WAIT
    req_valid = 1; req_addr = 32'h0000_5004; req_funct3 = 3'd2; req_rd = 5'd9;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    chk("mid_read_before_rst", dmem_read, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_read_async", dmem_read, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst = 0;
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_resp = 0;
    chk("post_rst_resp_ignored", rsp_valid, 0);
    chk("post_rst_no_read", dmem_read, 0);
    $display("txn reset_in_wait addr=00005004");
    do_load("after_rst", 32'h0000_5006, 3'd1, 32'h7FFF_0000, 1, 0, 0, 0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      do_load($sformatf("rnd%0d", i), $urandom, 3'($urandom_range(0, 7)), $urandom,
              $urandom_range(1, MW + 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
